circle_point_seq: RTL and testbench

- Sequencer that walks a full discrete circle of radius R centred on the origin, clockwise, starting and ending at (0,R).
- Each step computes the three candidate error terms for the current quadrant and picks the best one.
- Emits one (x,y) point per step over a valid/ready stream to the downstream voxel/frame writer.
- Sits between the shape command decoder (start, R) and the display buffer writer.

---
 rtl/circle_pkg.sv | 9 +
 rtl/circle_cand_err.sv | 45 ++++
 rtl/circle_point_seq.sv | 123 ++++++++++++
 tb/tb_circle_point_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// circle_pkg: shared types and widths for the circle point sequencer.
package circle_pkg;
  typedef enum logic [2:0] {IDLE, EMIT, CALC, STEP, FIN} state_t;
  typedef enum logic [1:0] {Q_PP, Q_PN, Q_NN, Q_NP} quad_t;
  typedef enum logic [1:0] {SEL_D1, SEL_D2, SEL_D3} sel_t;
  function automatic int err_w(input int w);
    return 2 * w + 2;
  endfunction
endpackage

// File: rtl/circle_cand_err.sv
// circle_cand_err: three clockwise candidate points and their signed radial errors.
module circle_cand_err
  import circle_pkg::*;
#(
  parameter int W = 16
) (
  input  logic signed [W-1:0]         x,
  input  logic signed [W-1:0]         y,
  input  logic signed [err_w(W)-1:0]  rsq,
  output logic signed [W-1:0]         c1x,
  output logic signed [W-1:0]         c1y,
  output logic signed [W-1:0]         c2x,
  output logic signed [W-1:0]         c2y,
  output logic signed [W-1:0]         c3x,
  output logic signed [W-1:0]         c3y,
  output logic signed [err_w(W)-1:0]  d1,
  output logic signed [err_w(W)-1:0]  d2,
  output logic signed [err_w(W)-1:0]  d3
);
  localparam int EW = err_w(W);
  quad_t q;
  logic signed [W:0] xe, ye, sx, sy, xs, ys;
  function automatic logic signed [EW-1:0] sq(input logic signed [W:0] v);
    return EW'(v) * EW'(v);
  endfunction
  // errors use W+1-bit candidates so x+-1 at the radius limit cannot wrap
  always_comb begin
    q = x[W-1] ? (y[W-1] ? Q_NN : Q_NP) : (y[W-1] ? Q_PN : Q_PP);
    sx = (q == Q_PP || q == Q_NP) ? (W+1)'(1) : '1;
    sy = (q == Q_PP || q == Q_PN) ? '1 : (W+1)'(1);
    xe = (W+1)'(x);
    ye = (W+1)'(y);
    xs = xe + sx;
    ys = ye + sy;
    d1 = sq(xs) + sq(ye) - rsq;
    d2 = sq(xs) + sq(ys) - rsq;
    d3 = sq(xe) + sq(ys) - rsq;
    c1x = W'(xs);
    c1y = y;
    c2x = W'(xs);
    c2y = W'(ys);
    c3x = x;
    c3y = W'(ys);
  end
endmodule

// File: rtl/circle_point_seq.sv
// circle_point_seq: clockwise discrete circle walker streaming (x,y) points.
// Define CIRCLE_CENTER_OFFSET_EN to add latched cx/cy centre offsets to the outputs.
module circle_point_seq
  import circle_pkg::*;
#(
  parameter int W         = 16,
  parameter int MAX_STEPS = 65535
) (
  input  logic                mclock,
  input  logic                reset,
  input  logic                start,
  input  logic [W-2:0]        r,
  output logic                busy,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic signed [W-1:0] pt_x,
  output logic signed [W-1:0] pt_y,
  output logic                done,
  output logic                abort
`ifdef CIRCLE_CENTER_OFFSET_EN
  ,
  input  logic signed [W-1:0] cx,
  input  logic signed [W-1:0] cy
`endif
);
  localparam int EW = err_w(W);
  localparam int CW = $clog2(MAX_STEPS + 1);
  state_t state, nxt;
  sel_t sel;
  logic signed [W-1:0] x, y, nx, ny, c1x, c1y, c2x, c2y, c3x, c3y;
  logic [W-2:0] rad;
  logic signed [EW-1:0] rsq, d1, d2, d3, d1q, d2q, d3q, a1, a2, a3;
  logic [CW-1:0] cnt;
  logic abt, hs, last, at_start;

  circle_cand_err #(.W(W)) u_cand (
    .x(x), .y(y), .rsq(rsq),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y), .c3x(c3x), .c3y(c3y),
    .d1(d1), .d2(d2), .d3(d3)
  );

  always_ff @(posedge mclock or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? EMIT : IDLE;
      EMIT:    nxt = !pt_ready ? EMIT : (rad == '0 || last) ? FIN : CALC;
      CALC:    nxt = STEP;
      STEP:    nxt = at_start ? FIN : EMIT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state == EMIT || state == CALC || state == STEP;
    pt_valid = state == EMIT;
    done = state == FIN;
    abort = state == FIN && abt;
  end

  // d2 wins ties so diagonal moves are preferred, then d1, then d3
  always_comb begin
    a1 = d1q[EW-1] ? -d1q : d1q;
    a2 = d2q[EW-1] ? -d2q : d2q;
    a3 = d3q[EW-1] ? -d3q : d3q;
    sel = (a2 <= a1 && a2 <= a3) ? SEL_D2 : (a1 <= a3) ? SEL_D1 : SEL_D3;
    nx = sel == SEL_D1 ? c1x : sel == SEL_D2 ? c2x : c3x;
    ny = sel == SEL_D1 ? c1y : sel == SEL_D2 ? c2y : c3y;
    at_start = nx == '0 && ny == W'(rad);
    hs = state == EMIT && pt_ready;
    last = cnt + CW'(1) == CW'(MAX_STEPS);
  end

  always_ff @(posedge mclock or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
      rad <= '0;
      rsq <= '0;
      cnt <= '0;
      abt <= 1'b0;
      d1q <= '0;
      d2q <= '0;
      d3q <= '0;
    end else if (state == IDLE && start) begin
      rad <= r;
      rsq <= EW'(r) * EW'(r);
      x <= '0;
      y <= W'(r);
      cnt <= '0;
      abt <= 1'b0;
    end else if (hs) begin
      cnt <= cnt + CW'(1);
      abt <= rad != '0 && last;
    end else if (state == CALC) begin
      d1q <= d1;
      d2q <= d2;
      d3q <= d3;
    end else if (state == STEP) begin
      x <= nx;
      y <= ny;
    end

`ifdef CIRCLE_CENTER_OFFSET_EN
  logic signed [W-1:0] ox, oy;
  always_ff @(posedge mclock or posedge reset)
    if (reset) begin
      ox <= '0;
      oy <= '0;
    end else if (state == IDLE && start) begin
      ox <= cx;
      oy <= cy;
    end
  assign pt_x = x + ox;
  assign pt_y = y + oy;
`else
  assign pt_x = x;
  assign pt_y = y;
`endif
endmodule

// File: tb/tb_circle_point_seq.sv
// tb_circle_point_seq: scoreboard bench with a plain-integer circle walk model.
module tb_circle_point_seq;
  localparam int W = 16;
  typedef struct {int x; int y;} pt_t;
  typedef struct {bit ab; int lat;} dn_t;
  logic clk = 0, rst = 1, start = 0, pt_ready = 0, start2 = 0;
  logic [W-2:0] r = '0, r2 = '0;
  logic busy, pt_valid, done, abort, busy2, valid2, done2, abort2;
  logic signed [W-1:0] pt_x, pt_y, px2, py2;
  pt_t exp_pts[$];
  dn_t exp_dn[$];
  int tests = 0, fails = 0, cyc = 0, last_hs = 0, done_cnt = 0, hs_cnt = 0, cur_r = 0;
  bit stall_en = 0, held = 0;
  logic signed [W-1:0] hx, hy;

  always #5 clk = ~clk;

  circle_point_seq #(.W(W)) dut (
    .mclock(clk), .reset(rst), .start(start), .r(r), .busy(busy),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .done(done), .abort(abort)
  );

  circle_point_seq #(.W(W), .MAX_STEPS(4)) dut_lim (
    .mclock(clk), .reset(rst), .start(start2), .r(r2), .busy(busy2),
    .pt_valid(valid2), .pt_ready(1'b1), .pt_x(px2), .pt_y(py2),
    .done(done2), .abort(abort2)
  );

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int aerr(input int x, input int y, input int rr);
    int d;
    d = x * x + y * y - rr * rr;
    return d < 0 ? -d : d;
  endfunction

  // clockwise tangent: x moves with the sign of y, y against the sign of x
  task automatic model(input int rr, input int maxs);
    int x, y, n, sx, sy, e1, e2, e3;
    pt_t p;
    dn_t d;
    x = 0; y = rr; n = 0;
    forever begin
      p.x = x; p.y = y;
      exp_pts.push_back(p);
      n++;
      if (rr == 0 || n == maxs) begin
        d.ab = rr != 0; d.lat = 1;
        exp_dn.push_back(d);
        return;
      end
      sx = y >= 0 ? 1 : -1;
      sy = x >= 0 ? -1 : 1;
      e1 = aerr(x + sx, y, rr);
      e2 = aerr(x + sx, y + sy, rr);
      e3 = aerr(x, y + sy, rr);
      if (e2 <= e1 && e2 <= e3) begin x += sx; y += sy; end
      else if (e1 <= e3) x += sx;
      else y += sy;
      if (x == 0 && y == rr) begin
        d.ab = 0; d.lat = 3;
        exp_dn.push_back(d);
        return;
      end
    end
  endtask

  task automatic push_r1();
    int xs[6] = '{0, 1, 1, 0, -1, -1};
    int ys[6] = '{1, 0, -1, -1, -1, 0};
    pt_t p;
    dn_t d;
    for (int i = 0; i < 6; i++) begin
      p.x = xs[i]; p.y = ys[i];
      exp_pts.push_back(p);
    end
    d.ab = 0; d.lat = 3;
    exp_dn.push_back(d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1 pt_ready = stall_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
  end

  always @(negedge clk) begin : mon
    pt_t p;
    dn_t d;
    int e;
    if (rst) held = 0;
    else begin
      if (held) begin
        chk("stall_valid", int'(pt_valid), 1);
        chk("stall_x", int'(pt_x), int'(hx));
        chk("stall_y", int'(pt_y), int'(hy));
      end
      held = pt_valid && !pt_ready;
      hx = pt_x; hy = pt_y;
      if (pt_valid && pt_ready) begin
        hs_cnt++;
        last_hs = cyc;
        if (exp_pts.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_point: got (%0d,%0d), expected none", pt_x, pt_y);
        end else begin
          p = exp_pts.pop_front();
          chk("pt_x", int'(pt_x), p.x);
          chk("pt_y", int'(pt_y), p.y);
        end
        e = aerr(int'(pt_x), int'(pt_y), cur_r);
        chk("on_circle", int'(e <= 2 * cur_r), 1);
      end
      if (done) begin
        done_cnt++;
        if (exp_dn.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_done: got done=1, expected 0");
        end else begin
          d = exp_dn.pop_front();
          chk("abort", int'(abort), int'(d.ab));
          chk("done_lat", cyc - last_hs, d.lat);
        end
      end else if (abort) begin
        tests++; fails++;
        $display("FAIL abort_alone: got abort=1 without done, expected 0");
      end
    end
  end

  task automatic pulse_start(input int rr);
    @(posedge clk);
    #1 start = 1; r = (W-1)'(rr);
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic walk(input int rr, input bit stall, input bit use_model, input int busy_r);
    int n0, t;
    cur_r = rr; stall_en = stall;
    if (use_model) model(rr, 65535);
    n0 = done_cnt;
    pulse_start(rr);
    @(negedge clk);
    chk("first_valid", int'(pt_valid), 1);
    chk("busy", int'(busy), 1);
    if (busy_r >= 0) begin
      repeat (3) @(posedge clk);
      #1 start = 1; r = (W-1)'(busy_r);
      @(posedge clk);
      #1 start = 0;
    end
    t = 0;
    while (done_cnt == n0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt == n0) begin
      tests++; fails++;
      $display("FAIL walk_timeout: got no done after %0d cycles, expected done", t);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after", int'(pt_valid), 0);
    chk("leftover_pts", exp_pts.size(), 0);
    exp_pts.delete();
    exp_dn.delete();
  endtask

  task automatic reset_mid();
    int h0, t;
    cur_r = 4; stall_en = 0;
    model(4, 65535);
    h0 = hs_cnt;
    pulse_start(4);
    t = 0;
    while (hs_cnt - h0 < 5 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_points", hs_cnt - h0, 5);
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(pt_valid), 0);
    chk("rst_x", int'(pt_x), 0);
    chk("rst_y", int'(pt_y), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_abort", int'(abort), 0);
    exp_pts.delete();
    exp_dn.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic lim_test();
    pt_t p;
    dn_t d;
    int n, lh;
    bit fin;
    model(3, 4);
    n = 0; lh = 0; fin = 0;
    @(posedge clk);
    #1 start2 = 1; r2 = 3;
    @(posedge clk);
    #1 start2 = 0;
    for (int t = 0; t < 200 && !fin; t++) begin
      @(negedge clk);
      if (valid2) begin
        n++; lh = t;
        if (exp_pts.size() != 0) begin
          p = exp_pts.pop_front();
          chk("lim_x", int'(px2), p.x);
          chk("lim_y", int'(py2), p.y);
        end
      end
      if (done2) begin
        fin = 1;
        if (exp_dn.size() != 0) begin
          d = exp_dn.pop_front();
          chk("lim_abort", int'(abort2), int'(d.ab));
          chk("lim_lat", t - lh, d.lat);
        end
      end
    end
    chk("lim_done", int'(fin), 1);
    chk("lim_count", n, 4);
    exp_pts.delete();
    exp_dn.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", int'(busy), 0);
    chk("init_valid", int'(pt_valid), 0);
    chk("init_x", int'(pt_x), 0);
    chk("init_y", int'(pt_y), 0);
    chk("init_done", int'(done), 0);
    chk("init_abort", int'(abort), 0);
    chk("init_busy2", int'(busy2), 0);
    rst = 0;
    cur_r = 1; push_r1(); walk(1, 0, 0, -1);
    walk(0, 0, 1, -1);
    walk(5, 0, 1, -1);
    walk(5, 1, 1, -1);
    walk(3, 0, 1, 7);
    reset_mid();
    cur_r = 1; push_r1(); walk(1, 0, 0, -1);
    lim_test();
    for (int i = 0; i < 4; i++) walk(int'($urandom_range(2, 12)), 1, 1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
